// File: rtl/ghost_mode_scheduler.sv
// Frame-rate scheduler for the shared ghost behaviour mode: scatter/chase waves,
// frightened mode on power pellets, per-ghost eating and the reverse/score pulses.
module ghost_mode_scheduler #(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int NUM_WAVES      = 4,
  parameter int CNT_W          = 11
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       hasMoved,
  input  logic       isDefeated,
  input  logic       power_pellet,
  input  logic [2:0] ghost_eaten,
  output logic [1:0] mode,
  output logic [2:0] frightened,
  output logic       flash,
  output logic       reverse,
  output logic [2:0] wave,
  output logic       eat_pulse,
  output logic [1:0] eat_idx
);

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_SCATTER = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_FRIGHT  = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] SCATTER_LAST = CNT_W'(SCATTER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CHASE_LAST   = CNT_W'(CHASE_FRAMES - 1);
  localparam logic [CNT_W-1:0] FRIGHT_LAST  = CNT_W'(FRIGHT_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLASH_START  = CNT_W'(FRIGHT_FRAMES - FLASH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       LAST_WAVE    = 3'(NUM_WAVES - 1);

  mode_e            mode_q, mode_d;
  mode_e            saved_mode_q, saved_mode_d;
  logic [CNT_W-1:0] wave_timer_q, wave_timer_d;
  logic [CNT_W-1:0] saved_timer_q, saved_timer_d;
  logic [CNT_W-1:0] fright_timer_q, fright_timer_d;
  logic [2:0]       frightened_q, frightened_d;
  logic             flash_q, flash_d;
  logic             reverse_q, reverse_d;
  logic [2:0]       wave_q, wave_d;
  logic             eat_pulse_q, eat_pulse_d;
  logic [1:0]       eat_idx_q, eat_idx_d;
  logic [1:0]       eat_cnt_q, eat_cnt_d;

  logic [2:0]       eat_hit;
  logic [2:0]       eat_sel;

  // Isolate the lowest-index ghost that is both overlapped and still frightened.
  assign eat_hit = ghost_eaten & frightened_q;
  assign eat_sel = eat_hit & (~eat_hit + 3'd1);

  always_comb begin
    mode_d         = mode_q;
    saved_mode_d   = saved_mode_q;
    wave_timer_d   = wave_timer_q;
    saved_timer_d  = saved_timer_q;
    fright_timer_d = fright_timer_q;
    frightened_d   = frightened_q;
    wave_d         = wave_q;
    eat_idx_d      = eat_idx_q;
    eat_cnt_d      = eat_cnt_q;
    reverse_d      = 1'b0;
    eat_pulse_d    = 1'b0;

    if (!isDefeated) begin
      case (mode_q)
        MODE_IDLE: begin
          if (hasMoved) begin
            mode_d       = MODE_SCATTER;
            wave_timer_d = '0;
            wave_d       = '0;
          end
        end

        MODE_SCATTER, MODE_CHASE: begin
          if (power_pellet) begin
            // The pellet beats a same-frame expiry, so the saved timer may hold the terminal count.
            saved_mode_d   = mode_q;
            saved_timer_d  = wave_timer_q;
            mode_d         = MODE_FRIGHT;
            fright_timer_d = '0;
            frightened_d   = 3'b111;
            eat_cnt_d      = '0;
            reverse_d      = 1'b1;
          end else if (hasMoved) begin
            if (mode_q == MODE_SCATTER) begin
              if (wave_timer_q == SCATTER_LAST) begin
                mode_d       = MODE_CHASE;
                wave_timer_d = '0;
                reverse_d    = 1'b1;
              end else begin
                wave_timer_d = wave_timer_q + CNT_ONE;
              end
            end else if (wave_q == LAST_WAVE) begin
              if (wave_timer_q != CHASE_LAST) begin
                wave_timer_d = wave_timer_q + CNT_ONE;
              end
            end else if (wave_timer_q == CHASE_LAST) begin
              mode_d       = MODE_SCATTER;
              wave_d       = wave_q + 3'd1;
              wave_timer_d = '0;
              reverse_d    = 1'b1;
            end else begin
              wave_timer_d = wave_timer_q + CNT_ONE;
            end
          end
        end

        MODE_FRIGHT: begin
          if (power_pellet) begin
            fright_timer_d = '0;
            frightened_d   = 3'b111;
            reverse_d      = 1'b1;
          end else begin
            if (|eat_sel) begin
              frightened_d = frightened_q & ~eat_sel;
              eat_pulse_d  = 1'b1;
              eat_idx_d    = eat_cnt_q;
              eat_cnt_d    = (eat_cnt_q == 2'd3) ? 2'd3 : eat_cnt_q + 2'd1;
            end
            // All ghosts eaten on an earlier frame, or the fright time has run out.
            if ((frightened_q == 3'b000) || (hasMoved && (fright_timer_q == FRIGHT_LAST))) begin
              mode_d         = saved_mode_q;
              wave_timer_d   = saved_timer_q;
              frightened_d   = '0;
              fright_timer_d = '0;
            end else if (hasMoved) begin
              fright_timer_d = fright_timer_q + CNT_ONE;
            end
          end
        end

        default: ;
      endcase
    end

    flash_d = (mode_d == MODE_FRIGHT) && (fright_timer_d >= FLASH_START);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      mode_q         <= MODE_IDLE;
      saved_mode_q   <= MODE_IDLE;
      wave_timer_q   <= '0;
      saved_timer_q  <= '0;
      fright_timer_q <= '0;
      frightened_q   <= '0;
      flash_q        <= 1'b0;
      reverse_q      <= 1'b0;
      wave_q         <= '0;
      eat_pulse_q    <= 1'b0;
      eat_idx_q      <= '0;
      eat_cnt_q      <= '0;
    end else begin
      mode_q         <= mode_d;
      saved_mode_q   <= saved_mode_d;
      wave_timer_q   <= wave_timer_d;
      saved_timer_q  <= saved_timer_d;
      fright_timer_q <= fright_timer_d;
      frightened_q   <= frightened_d;
      flash_q        <= flash_d;
      reverse_q      <= reverse_d;
      wave_q         <= wave_d;
      eat_pulse_q    <= eat_pulse_d;
      eat_idx_q      <= eat_idx_d;
      eat_cnt_q      <= eat_cnt_d;
    end
  end

  assign mode       = mode_q;
  assign frightened = frightened_q;
  assign flash      = flash_q;
  assign reverse    = reverse_q;
  assign wave       = wave_q;
  assign eat_pulse  = eat_pulse_q;
  assign eat_idx    = eat_idx_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed scenarios plus random frames, all outputs
// compared every frame against a frame-level behavioural model.
module tb_ghost_mode_scheduler;

  localparam int SF = 4;
  localparam int CF = 6;
  localparam int FF = 5;
  localparam int FL = 2;
  localparam int NW = 2;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       hasMoved;
  logic       isDefeated;
  logic       power_pellet;
  logic [2:0] ghost_eaten;
  logic [1:0] mode;
  logic [2:0] frightened;
  logic       flash;
  logic       reverse;
  logic [2:0] wave;
  logic       eat_pulse;
  logic [1:0] eat_idx;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int frame_no = 0;

  // model state
  int       m_mode, m_wave, m_wt, m_ft, m_smode, m_st, m_ec, m_eidx;
  logic [2:0] m_fr;
  bit       m_flash, m_rev, m_ep;

  ghost_mode_scheduler #(
    .SCATTER_FRAMES(SF),
    .CHASE_FRAMES  (CF),
    .FRIGHT_FRAMES (FF),
    .FLASH_FRAMES  (FL),
    .NUM_WAVES     (NW),
    .CNT_W         (11)
  ) dut (
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .hasMoved    (hasMoved),
    .isDefeated  (isDefeated),
    .power_pellet(power_pellet),
    .ghost_eaten (ghost_eaten),
    .mode        (mode),
    .frightened  (frightened),
    .flash       (flash),
    .reverse     (reverse),
    .wave        (wave),
    .eat_pulse   (eat_pulse),
    .eat_idx     (eat_idx)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (frame %0d)", tag, got, exp, frame_no);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wave = 0; m_wt = 0; m_ft = 0; m_smode = 0; m_st = 0;
    m_ec = 0; m_eidx = 0; m_fr = 3'b000; m_flash = 0; m_rev = 0; m_ep = 0;
  endtask

  // One frame of the game rules, mode numbers as on the mode output.
  task automatic model_edge(input bit mv, input bit dft, input bit pp, input logic [2:0] ge);
    bit found;
    bit leave;
    int lim;
    m_rev = 0;
    m_ep  = 0;
    if (!dft) begin
      if (m_mode == 0) begin
        if (mv) begin m_mode = 1; m_wt = 0; m_wave = 0; end
      end else if (m_mode == 1 || m_mode == 2) begin
        if (pp) begin
          m_smode = m_mode; m_st = m_wt;
          m_mode = 3; m_ft = 0; m_fr = 3'b111; m_ec = 0; m_rev = 1;
        end else if (mv) begin
          lim = (m_mode == 1) ? SF : CF;
          if (m_mode == 2 && m_wave == NW - 1) begin
            if (m_wt < CF - 1) m_wt++;
          end else if (m_wt == lim - 1) begin
            if (m_mode == 2) m_wave++;
            m_mode = (m_mode == 1) ? 2 : 1;
            m_wt = 0;
            m_rev = 1;
          end else begin
            m_wt++;
          end
        end
      end else begin
        if (pp) begin
          m_ft = 0; m_fr = 3'b111; m_rev = 1;
        end else begin
          leave = (m_fr == 3'b000) || (mv && m_ft == FF - 1);
          found = 0;
          for (int i = 0; i < 3; i++) begin
            if (!found && ge[i] && m_fr[i]) begin
              found = 1;
              m_fr[i] = 1'b0;
              m_ep = 1;
              m_eidx = m_ec;
              if (m_ec < 3) m_ec++;
            end
          end
          if (leave) begin
            m_mode = m_smode; m_wt = m_st; m_fr = 3'b000; m_ft = 0;
          end else if (mv) begin
            m_ft++;
          end
        end
      end
    end
    m_flash = (m_mode == 3) && (m_ft >= FF - FL);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_mode"},  mode,       m_mode);
    check({tag, "_fr"},    frightened, m_fr);
    check({tag, "_flash"}, flash,      m_flash);
    check({tag, "_rev"},   reverse,    m_rev);
    check({tag, "_wave"},  wave,       m_wave);
    check({tag, "_ep"},    eat_pulse,  m_ep);
    check({tag, "_eidx"},  eat_idx,    m_eidx);
  endtask

  task automatic step(input string tag, input bit mv, input bit dft, input bit pp, input logic [2:0] ge);
    hasMoved = mv; isDefeated = dft; power_pellet = pp; ghost_eaten = ge;
    @(posedge frame_clk);
    model_edge(mv, dft, pp, ge);
    #1;
    frame_no++;
    $display("%s frame %0d mv=%0d def=%0d pp=%0d ge=%b -> mode=%0d fr=%b flash=%0d rev=%0d wave=%0d ep=%0d eidx=%0d",
             tag, frame_no, mv, dft, pp, ge, mode, frightened, flash, reverse, wave, eat_pulse, eat_idx);
    check_all(tag);
  endtask

  task automatic do_reset();
    hasMoved = 0; isDefeated = 0; power_pellet = 0; ghost_eaten = 3'b000;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  initial begin
    int n;
    Reset = 1'b1; hasMoved = 0; isDefeated = 0; power_pellet = 0; ghost_eaten = 3'b000;
    repeat (2) @(posedge frame_clk);
    #1;
    model_reset();
    check_all("rst0");
    Reset = 1'b0;

    // wave sequence
    step("idle", 0, 0, 0, 3'b000);
    step("idle", 0, 0, 0, 3'b000);
    for (int e = 1; e <= 65; e++) begin
      step("wave", 1, 0, 0, 3'b000);
      if (e == 1)  check("t1_e1_mode", mode, 1);
      if (e == 5)  begin check("t1_e5_mode", mode, 2); check("t1_e5_rev", reverse, 1); end
      if (e == 11) begin check("t1_e11_mode", mode, 1); check("t1_e11_wave", wave, 1); end
      if (e == 15) check("t1_e15_mode", mode, 2);
      if (e == 65) begin check("t1_e65_mode", mode, 2); check("t1_e65_wave", wave, 1); end
    end

    // pellet mid-scatter, flash window and return
    do_reset();
    repeat (3) step("scat", 1, 0, 0, 3'b000);
    step("pel", 1, 0, 1, 3'b000);
    check("t2_mode", mode, 3);
    check("t2_fr", frightened, 3'b111);
    check("t2_rev", reverse, 1);
    for (int k = 1; k <= 5; k++) begin
      step("fri", 1, 0, 0, 3'b000);
      if (k < 5) check("t2_flash", flash, (k >= 3) ? 1 : 0);
      else       check("t2_ret_mode", mode, 1);
    end
    step("ret", 1, 0, 0, 3'b000);
    check("t2_ret1_mode", mode, 1);
    step("ret", 1, 0, 0, 3'b000);
    check("t2_ret2_mode", mode, 2);

    // eating order and early exit
    step("pel", 1, 0, 1, 3'b000);
    step("eat", 1, 0, 0, 3'b101);
    check("t3_red_ep", eat_pulse, 1); check("t3_red_idx", eat_idx, 0); check("t3_red_fr", frightened, 3'b110);
    step("eat", 1, 0, 0, 3'b101);
    check("t3_aqua_idx", eat_idx, 1); check("t3_aqua_fr", frightened, 3'b010);
    step("eat", 1, 0, 0, 3'b010);
    check("t3_green_idx", eat_idx, 2); check("t3_green_fr", frightened, 3'b000); check("t3_green_mode", mode, 3);
    step("exit", 1, 0, 0, 3'b000);
    check("t3_exit_mode", mode, 2);

    // pellet on the scatter expiry frame
    n = 0;
    while (!(m_mode == 1 && m_wt == SF - 1) && n < 50) begin
      step("run", 1, 0, 0, 3'b000);
      n++;
    end
    check("t4_reach", (n < 50) ? 1 : 0, 1);
    step("pel", 1, 0, 1, 3'b000);
    check("t4_mode", mode, 3);
    repeat (5) step("fri", 1, 0, 0, 3'b000);
    check("t4_ret_mode", mode, 1);
    step("ret", 1, 0, 0, 3'b000);
    check("t4_chase_mode", mode, 2);
    check("t4_chase_rev", reverse, 1);

    // freeze mid-chase with pellets
    do_reset();
    n = 0;
    while (!(m_mode == 2 && m_wt == 2) && n < 50) begin
      step("run", 1, 0, 0, 3'b000);
      n++;
    end
    check("t5_reach", (n < 50) ? 1 : 0, 1);
    for (int k = 0; k < 10; k++) begin
      step("frz", 1, 1, (k % 2 == 0), 3'b111);
      check("t5_frz_mode", mode, 2);
      check("t5_frz_rev", reverse, 0);
    end
    n = 0;
    do begin
      step("rel", 1, 0, 0, 3'b000);
      n++;
    end while (mode != 2'd1 && n < 20);
    check("t5_resume_frames", n, 4);

    // asynchronous reset in the middle of fright
    step("pel", 1, 0, 1, 3'b000);
    repeat (3) step("fri", 1, 0, 0, 3'b000);
    check("t6_pre_flash", flash, 1);
    check("t6_pre_wave", wave, 1);
    #3;
    Reset = 1'b1;
    #1;
    check("t6_rst_mode", mode, 0);
    check("t6_rst_fr", frightened, 0);
    check("t6_rst_flash", flash, 0);
    check("t6_rst_wave", wave, 0);
    model_reset();
    #2;
    Reset = 1'b0;

    // random frames
    for (int k = 0; k < 500; k++) begin
      step("rnd",
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 24) == 0),
           {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
Name: ghost_mode_scheduler

Overview:
- Frame-rate controller that sequences the behaviour mode shared by the three ghosts (red, green, aqua).
- Runs the scatter/chase wave timer, frightened mode on power-pellet events, and per-ghost eaten handling.
- Emits a direction-reverse pulse on mode changes and an eat-score pulse.
- Sits between the pellet/collision logic and the ghost movers. Movers use `mode` and `frightened` to select their target and motion.

Parameters:
- SCATTER_FRAMES, 420, frames spent in SCATTER per wave
- CHASE_FRAMES, 1200, frames spent in CHASE per wave
- FRIGHT_FRAMES, 360, frames spent in FRIGHT
- FLASH_FRAMES, 120, final FRIGHT frames during which `flash` is asserted (must be < FRIGHT_FRAMES)
- NUM_WAVES, 4, number of waves; CHASE of the last wave is permanent
- CNT_W, 11, width of frame timers (must hold max(SCATTER_FRAMES, CHASE_FRAMES, FRIGHT_FRAMES))

Ports:
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  clock, one edge per video frame
- hasMoved  in  1  1 once pacman has started moving; gates all timers
- isDefeated  in  1  pacman defeated; freezes all state
- power_pellet  in  1  one-frame pulse, power pellet consumed
- ghost_eaten  in  3  level per ghost [0]=red [1]=green [2]=aqua; pacman overlapping that ghost
- mode  out  2  0=IDLE 1=SCATTER 2=CHASE 3=FRIGHT
- frightened  out  3  per-ghost frightened flag
- flash  out  1  FRIGHT ending soon
- reverse  out  1  one-frame pulse, ghosts reverse direction
- wave  out  3  index of current scatter/chase wave
- eat_pulse  out  1  one-frame pulse, a frightened ghost was eaten
- eat_idx  out  2  score index for eat_pulse (points = 200 << eat_idx)

Behaviour:
- Reset (async): mode=IDLE, frightened=0, flash=0, reverse=0, wave=0, eat_pulse=0, eat_idx=0, all timers=0, saved mode/timer=0, eat_count=0.
- All updates occur on posedge frame_clk. reverse and eat_pulse default to 0 every frame.
- Freeze: if isDefeated=1, no register changes except reverse=0 and eat_pulse=0. Inputs are ignored. isDefeated has priority over everything except Reset.
- IDLE: on a frame with hasMoved=1, go to SCATTER with timer=0 and wave=0. power_pellet and ghost_eaten are ignored in IDLE.
- Timers increment by 1 per frame only when hasMoved=1.
- SCATTER: when timer == SCATTER_FRAMES-1, go to CHASE, set timer=0, pulse reverse.
- CHASE, wave < NUM_WAVES-1: when timer == CHASE_FRAMES-1, set wave+1, go to SCATTER, set timer=0, pulse reverse.
- CHASE, wave == NUM_WAVES-1: the timer holds and the state is permanent.
- power_pellet in SCATTER or CHASE:
  - Save the current mode and timer value; the wave timer pauses.
  - Go to FRIGHT with fright timer=0, frightened=3'b111, eat_count=0, and pulse reverse.
  - power_pellet wins over a same-frame expiry. The saved timer is the expiry value, so the expiry fires on the first frame after return.
- power_pellet in FRIGHT: fright timer=0, frightened=3'b111, eat_count unchanged, pulse reverse. The saved mode/timer are untouched.
- Eating, FRIGHT only, and only when power_pellet=0 that frame:
  - The lowest index i with ghost_eaten[i] & frightened[i] is serviced: clear frightened[i], eat_pulse=1, eat_idx=eat_count, eat_count=min(eat_count+1, 3).
  - One ghost is serviced per frame. Higher-index requests are serviced on later frames while their level persists.
- FRIGHT exit: when fright timer == FRIGHT_FRAMES-1, or frightened becomes 3'b000 after an eat, restore the saved mode and timer next frame.
  - Exit clears frightened and flash. No reverse pulse on exit.
- flash = 1 iff mode==FRIGHT and fright timer >= FRIGHT_FRAMES-FLASH_FRAMES. Registered, aligned with the timer.
- hasMoved=0 after start: timers hold and no transitions occur. Pellet and eat events are still processed.
- All outputs are registered. Arithmetic is unsigned; timers never wrap because they reset at the terminal count.

Test Plan:
All tests use SCATTER_FRAMES=4, CHASE_FRAMES=6, FRIGHT_FRAMES=5, FLASH_FRAMES=2, NUM_WAVES=2.
- Reset, then hasMoved=1 from frame 1 -> mode IDLE→SCATTER at edge 1. CHASE at edge 5 with a reverse pulse. SCATTER with wave=1 at edge 11. CHASE at edge 15. Stays CHASE for 50 frames with wave=1.
- Pellet at SCATTER timer=2 -> mode=3, frightened=111, reverse=1 for one frame. flash=1 on fright timers 3 and 4. Returns to SCATTER with timer=2. CHASE follows 2 frames later.
- In FRIGHT, ghost_eaten=3'b101 held -> red eaten first (eat_idx=0), aqua eaten next frame (eat_idx=1). frightened=010.
- Then green eaten -> eat_idx=2, frightened=000, mode restored on the next edge.
- Pellet on the same frame as SCATTER expiry -> FRIGHT entered, no CHASE. After FRIGHT, CHASE entered one frame after return.
- isDefeated=1 for 10 frames mid-CHASE while pellet pulses -> all outputs frozen and the pellet is ignored. Timer resumes from its held value after release.
- Reset asserted mid-FRIGHT, asynchronously between clock edges -> outputs immediately mode=0, frightened=0, flash=0, wave=0.
